// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: baud tick, enable, serial line and frame results.
// ParityErr is present only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int unsigned NBITS = 8
);
  logic             tick;
  logic             RxEn;
  logic             Rx;
  logic [NBITS-1:0] RxData;
  logic             RxDone;
  logic             FrameErr;
  logic             Busy;
`ifdef UART_RX_PARITY_EN
  logic             ParityErr;
`endif

  modport master (
    output tick, RxEn, Rx,
`ifdef UART_RX_PARITY_EN
    input  ParityErr,
`endif
    input  RxData, RxDone, FrameErr, Busy
  );

  modport slave (
    input  tick, RxEn, Rx,
`ifdef UART_RX_PARITY_EN
    output ParityErr,
`endif
    output RxData, RxDone, FrameErr, Busy
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, NBITS data LSB first, stop; one-clock RxDone/FrameErr pulses.
// Optional even-parity bit checking enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned NBITS      = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic     Clk,
  input  logic     Rst_n,
  uart_rx_if.slave rx_if
);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic [1:0]       sync_q;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sync_q  <= '1;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      sync_q  <= {sync_q[0], rx_if.Rx};
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (!rx_if.RxEn) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
      bcnt_d  = '0;
    end else if (rx_if.tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tcnt_d  = '0;
          end
        end
        S_START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tcnt_q == T_FULL) begin
            shift_d = {rx_s, shift_q[NBITS-1:1]};
            tcnt_d  = '0;
            bcnt_d  = bcnt_q + BW'(1);
            if (bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tcnt_q == T_FULL) begin
            par_d   = rx_s;
            tcnt_d  = '0;
            state_d = S_STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tcnt_q == T_FULL) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            tcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
            perr_d  = ^{shift_q, par_q};
`endif
            // A low stop bit parks in BREAK so a held-low line cannot start a new frame.
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_if.RxData    = data_q;
    rx_if.RxDone    = done_q;
    rx_if.FrameErr  = ferr_q;
`ifdef UART_RX_PARITY_EN
    rx_if.ParityErr = perr_q;
    rx_if.Busy      = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
`else
    rx_if.Busy      = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_STOP);
`endif
  end
endmodule
